// File: rtl/board_status_scanner.sv
// Walks the selected minesweeper board one field per clock after each defuse event and
// registers defused/mine counts plus win/lose flags for the game-control FSM and status display.
module board_status_scanner (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          level,
    input  logic                start,
    input  logic [7:0][7:0]     mine_arr_easy,
    input  logic [9:0][9:0]     mine_arr_medium,
    input  logic [15:0][15:0]   mine_arr_hard,
    input  logic [7:0][7:0]     defuse_arr_easy,
    input  logic [9:0][9:0]     defuse_arr_medium,
    input  logic [15:0][15:0]   defuse_arr_hard,
    output logic                busy,
    output logic                status_valid,
    output logic [8:0]          defused_count,
    output logic [8:0]          mine_count,
    output logic                lose,
    output logic                win
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  lvl_q;
    logic [3:0]  x_q, y_q;
    logic [8:0]  def_acc, mine_acc;
    logic        hit_acc;
    logic        pending;

    logic        cell_mine, cell_def;
    logic [3:0]  last_idx;
    logic [8:0]  n_sq;
    logic        last_cell;
    logic        launch;

    // Live read of the current field from the latched board size.
    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        cell_mine = 1'b0;
        cell_def  = 1'b0;
        last_idx  = 4'd0;
        n_sq      = 9'd0;
        case (lvl_q)
            2'b01: begin
                cell_mine = mine_arr_easy[y_q[2:0]][x_q[2:0]];
                cell_def  = defuse_arr_easy[y_q[2:0]][x_q[2:0]];
                last_idx  = 4'd7;
                n_sq      = 9'd64;
            end
            2'b10: begin
                cell_mine = mine_arr_medium[y_q][x_q];
                cell_def  = defuse_arr_medium[y_q][x_q];
                last_idx  = 4'd9;
                n_sq      = 9'd100;
            end
            2'b11: begin
                cell_mine = mine_arr_hard[y_q][x_q];
                cell_def  = defuse_arr_hard[y_q][x_q];
                last_idx  = 4'd15;
                n_sq      = 9'd256;
            end
            default: ;
        endcase
    end

    assign last_cell = (x_q == last_idx) && (y_q == last_idx);
    // A request seen in DONE (or one collapsed into pending) rescans with no idle gap.
    assign launch    = (level != 2'b00) &&
                       (((state == S_IDLE) && start) ||
                        ((state == S_DONE) && (pending || start)));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (launch) state_nx = S_SCAN;
            S_SCAN:  if (last_cell) state_nx = S_DONE;
            S_DONE:  state_nx = launch ? S_SCAN : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lvl_q    <= 2'b00;
            x_q      <= 4'd0;
            y_q      <= 4'd0;
            def_acc  <= 9'd0;
            mine_acc <= 9'd0;
            hit_acc  <= 1'b0;
        end else if (launch) begin
            lvl_q    <= level;
            x_q      <= 4'd0;
            y_q      <= 4'd0;
            def_acc  <= 9'd0;
            mine_acc <= 9'd0;
            hit_acc  <= 1'b0;
        end else if (state == S_SCAN) begin
            def_acc  <= def_acc + {8'd0, cell_def};
            mine_acc <= mine_acc + {8'd0, cell_mine};
            hit_acc  <= hit_acc | (cell_mine & cell_def);
            if (x_q == last_idx) begin
                x_q <= 4'd0;
                y_q <= y_q + 4'd1;
            end else begin
                x_q <= x_q + 4'd1;
            end
        end
    end

    // Requests during a scan (or a level switch under it) collapse into one rescan.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                            pending <= 1'b0;
        else if (state == S_DONE)                            pending <= 1'b0;
        else if ((state == S_SCAN) && (start || (level != lvl_q))) pending <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_valid  <= 1'b0;
            defused_count <= 9'd0;
            mine_count    <= 9'd0;
            lose          <= 1'b0;
            win           <= 1'b0;
        end else begin
            status_valid <= (state == S_DONE);
            if (state == S_DONE) begin
                defused_count <= def_acc;
                mine_count    <= mine_acc;
                lose          <= hit_acc;
                win           <= !hit_acc && (def_acc == (n_sq - mine_acc));
            end
        end
    end

endmodule

// File: tb/tb_board_status_scanner.sv
// Randomized directed bench for board_status_scanner; expectations come from a whole-board
// counting model over a 16x16 scratch board that drives all three level arrays.
module tb_board_status_scanner;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [1:0]          level = 2'b00;
    logic                start = 1'b0;
    logic [7:0][7:0]     mine_arr_easy, defuse_arr_easy;
    logic [9:0][9:0]     mine_arr_medium, defuse_arr_medium;
    logic [15:0][15:0]   mine_arr_hard, defuse_arr_hard;
    logic                busy, status_valid, lose, win;
    logic [8:0]          defused_count, mine_count;

    bit mine_b [16][16];
    bit def_b  [16][16];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int def;
        int mine;
        bit lose;
        bit win;
    } ref_t;

    board_status_scanner dut (
        .clk               (clk),
        .rst               (rst),
        .level             (level),
        .start             (start),
        .mine_arr_easy     (mine_arr_easy),
        .mine_arr_medium   (mine_arr_medium),
        .mine_arr_hard     (mine_arr_hard),
        .defuse_arr_easy   (defuse_arr_easy),
        .defuse_arr_medium (defuse_arr_medium),
        .defuse_arr_hard   (defuse_arr_hard),
        .busy              (busy),
        .status_valid      (status_valid),
        .defused_count     (defused_count),
        .mine_count        (mine_count),
        .lose              (lose),
        .win               (win)
    );

    always #5 clk = ~clk;

    // Every level array shows the top-left corner of the same scratch board.
    always_comb begin
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                mine_arr_hard[y][x]   = mine_b[y][x];
                defuse_arr_hard[y][x] = def_b[y][x];
                if (y < 10 && x < 10) begin
                    mine_arr_medium[y][x]   = mine_b[y][x];
                    defuse_arr_medium[y][x] = def_b[y][x];
                end
                if (y < 8 && x < 8) begin
                    mine_arr_easy[y][x]   = mine_b[y][x];
                    defuse_arr_easy[y][x] = def_b[y][x];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic ref_t model(input int n);
        ref_t r;
        r.def  = 0;
        r.mine = 0;
        r.lose = 1'b0;
        for (int y = 0; y < n; y++)
            for (int x = 0; x < n; x++) begin
                r.def  += int'(def_b[y][x]);
                r.mine += int'(mine_b[y][x]);
                if (def_b[y][x] && mine_b[y][x]) r.lose = 1'b1;
            end
        r.win = !r.lose && (r.def == n * n - r.mine);
        return r;
    endfunction

    task automatic clear_board();
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) begin
                mine_b[y][x] = 1'b0;
                def_b[y][x]  = 1'b0;
            end
    endtask

    // Sets `count` distinct fields that currently hold neither a mine nor a defuse.
    task automatic place_random(input int n, input int count, input bit as_mine);
        int placed = 0;
        while (placed < count) begin
            int y = $urandom_range(0, n - 1);
            int x = $urandom_range(0, n - 1);
            if (!mine_b[y][x] && !def_b[y][x]) begin
                if (as_mine) mine_b[y][x] = 1'b1;
                else         def_b[y][x]  = 1'b1;
                placed++;
            end
        end
    endtask

    task automatic defuse_all_safe(input int n);
        for (int y = 0; y < n; y++)
            for (int x = 0; x < n; x++)
                if (!mine_b[y][x]) def_b[y][x] = 1'b1;
    endtask

    task automatic check_results(input string tag, input ref_t e);
        check({tag, "_defused"}, 32'(defused_count), e.def);
        check({tag, "_mines"},   32'(mine_count),    e.mine);
        check({tag, "_lose"},    32'(lose),          32'(e.lose));
        check({tag, "_win"},     32'(win),           32'(e.win));
    endtask

    // Counts edges from the start-sampling edge until status_valid shows, bounded.
    task automatic wait_valid(input string tag, input int exp_lat);
        int c = 0;
        do begin
            tick();
            c++;
        end while (!status_valid && c < 600);
        check({tag, "_latency"}, c, exp_lat);
    endtask

    task automatic run_scan(input string tag, input logic [1:0] lv, input int n);
        level = lv;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy_rise"}, 32'(busy), 1);
        wait_valid(tag, n * n + 1);
        check_results(tag, model(n));
        tick();
        check({tag, "_valid_one_cycle"}, 32'(status_valid), 0);
        check({tag, "_busy_fall"}, 32'(busy), 0);
    endtask

    initial begin
        ref_t e1, e2, e_prev;
        int   c, lat1, lat2, sy, sx, n;
        bit   busy_ok;

        clear_board();
        repeat (3) tick();
        check("reset_busy",   32'(busy), 0);
        check("reset_valid",  32'(status_valid), 0);
        check("reset_def",    32'(defused_count), 0);
        check("reset_mines",  32'(mine_count), 0);
        check("reset_lose",   32'(lose), 0);
        check("reset_win",    32'(win), 0);

        // Easy win, started on the very first cycle after reset release.
        place_random(8, 10, 1'b1);
        defuse_all_safe(8);
        rst   = 1'b1;
        level = 2'b01;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("easy_busy_rise", 32'(busy), 1);
        wait_valid("easy", 65);
        check_results("easy", model(8));
        check("easy_def_54", 32'(defused_count), 54);
        tick();
        check("easy_valid_one_cycle", 32'(status_valid), 0);

        // Medium lose: mined field (y=3, x=7) defused.
        clear_board();
        mine_b[3][7] = 1'b1;
        place_random(10, 14, 1'b1);
        place_random(10, 20, 1'b0);
        def_b[3][7] = 1'b1;
        run_scan("medium", 2'b10, 10);
        check("medium_lose_const", 32'(lose), 1);

        // Hard: one safe field left, then finish it.
        clear_board();
        place_random(16, 40, 1'b1);
        defuse_all_safe(16);
        do begin
            sy = $urandom_range(0, 15);
            sx = $urandom_range(0, 15);
        end while (mine_b[sy][sx]);
        def_b[sy][sx] = 1'b0;
        run_scan("hard_partial", 2'b11, 16);
        def_b[sy][sx] = 1'b1;
        run_scan("hard_full", 2'b11, 16);
        check("hard_win_const", 32'(win), 1);
        e_prev = model(16);

        // No-game level: start ignored, outputs hold.
        level = 2'b00;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("lvl0_busy", 32'(busy), 0);
        busy_ok = 1'b1;
        repeat (6) begin
            tick();
            if (busy || status_valid) busy_ok = 1'b0;
        end
        check("lvl0_quiet", 32'(busy_ok), 1);
        check_results("lvl0_hold", e_prev);

        // Mid-scan request with a field changed after it was already scanned.
        clear_board();
        def_b[0][0] = 1'b1;
        place_random(8, 6, 1'b1);
        defuse_all_safe(8);
        def_b[0][0] = 1'b0;
        e1 = model(8);
        level = 2'b01;
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0; lat1 = 0; lat2 = 0; busy_ok = 1'b1;
        while (lat2 == 0 && c < 400) begin
            tick();
            c++;
            if (c == 30) begin
                start = 1'b1;
                def_b[0][0] = 1'b1;
            end
            if (c == 31) start = 1'b0;
            if (c < 130 && !busy) busy_ok = 1'b0;
            if (status_valid) begin
                if (lat1 == 0) begin
                    lat1 = c;
                    check_results("rescan_first", e1);
                end else begin
                    lat2 = c;
                end
            end
        end
        e2 = model(8);
        check("rescan_first_latency",  lat1, 65);
        check("rescan_second_latency", lat2, 130);
        check("rescan_busy_held", 32'(busy_ok), 1);
        check_results("rescan_second", e2);
        check("rescan_win_after_fix", 32'(win), 1);
        tick();
        check("rescan_busy_fall", 32'(busy), 0);

        // Asynchronous reset in the middle of a hard scan.
        clear_board();
        place_random(16, 30, 1'b1);
        place_random(16, 100, 1'b0);
        level = 2'b11;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (50) tick();
        #2 rst = 1'b0;
        #1;
        check("midrst_busy",  32'(busy), 0);
        check("midrst_valid", 32'(status_valid), 0);
        check("midrst_def",   32'(defused_count), 0);
        check("midrst_mines", 32'(mine_count), 0);
        check("midrst_lose",  32'(lose), 0);
        check("midrst_win",   32'(win), 0);
        tick();
        tick();
        rst = 1'b1;
        run_scan("after_rst", 2'b11, 16);

        // Random boards at random levels; even passes are fully cleared (winning) boards.
        for (int it = 0; it < 4; it++) begin
            logic [1:0] lv;
            lv = 2'($urandom_range(1, 3));
            n  = (lv == 2'b01) ? 8 : (lv == 2'b10) ? 10 : 16;
            clear_board();
            for (int y = 0; y < n; y++)
                for (int x = 0; x < n; x++) begin
                    mine_b[y][x] = ($urandom_range(0, 6) == 0);
                    if (it % 2 == 0) def_b[y][x] = !mine_b[y][x];
                    else def_b[y][x] = mine_b[y][x] ? ($urandom_range(0, 15) == 0)
                                                    : ($urandom_range(0, 2) != 0);
                end
            run_scan($sformatf("rand%0d", it), lv, n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
